// File: rtl/framebuffer_client_if.sv
// rtl/framebuffer_client_if.sv - memory manager CPU-side port bundle
interface framebuffer_client_if #(
  parameter int X_BITS = 9,
  parameter int Y_BITS = 8
);
  logic [X_BITS-1:0] memoryXCoord;
  logic [Y_BITS-1:0] memoryYCoord;
  logic              memoryWriteRequest;
  logic              memoryReadRequest;
  logic [7:0]        memoryWriteData;
  logic [7:0]        memoryReadData;
  logic              memoryWriteComplete;
  logic              memoryReadComplete;

  // Initiator side (the framebuffer client)
  modport master (
    output memoryXCoord, memoryYCoord, memoryWriteRequest, memoryReadRequest, memoryWriteData,
    input  memoryReadData, memoryWriteComplete, memoryReadComplete
  );

  // Responder side (the memory manager)
  modport slave (
    input  memoryXCoord, memoryYCoord, memoryWriteRequest, memoryReadRequest, memoryWriteData,
    output memoryReadData, memoryWriteComplete, memoryReadComplete
  );
endinterface

// File: rtl/framebuffer_client.sv
// rtl/framebuffer_client.sv - rectangle-fill / pixel-read command initiator
module framebuffer_client #(
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240,
  parameter int X_BITS   = 9,
  parameter int Y_BITS   = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmdValid,
  output logic              cmdReady,
  input  logic              cmdOp,
  input  logic [X_BITS-1:0] cmdX,
  input  logic [Y_BITS-1:0] cmdY,
  input  logic [X_BITS-1:0] cmdWidth,
  input  logic [Y_BITS-1:0] cmdHeight,
  input  logic [7:0]        cmdColor,
  output logic [7:0]        readData,
  output logic              readDataValid,
  output logic              busy,
  framebuffer_client_if.master mem
);

  typedef enum logic [1:0] {IDLE, SETUP, REQ, STEP} stateType;

  localparam logic [X_BITS:0] xLimit = (X_BITS+1)'(SCREEN_W);
  localparam logic [Y_BITS:0] yLimit = (Y_BITS+1)'(SCREEN_H);

  stateType          state;
  logic              opRead;
  logic [X_BITS-1:0] xStart;
  logic [Y_BITS-1:0] yStart;
  logic [X_BITS-1:0] widthReg;
  logic [Y_BITS-1:0] heightReg;
  logic [7:0]        colorReg;
  logic [X_BITS:0]   xEnd;
  logic [Y_BITS:0]   yEnd;

  // One extra bit on every sum so edge-of-screen rectangles clip instead of wrapping
  logic [X_BITS:0] xSum;
  logic [Y_BITS:0] ySum;
  logic [X_BITS:0] xNext;
  logic [Y_BITS:0] yNext;
  logic            offScreen;
  logic            emptyFill;
  logic            completeSeen;

  assign xSum  = {1'b0, xStart} + {1'b0, widthReg};
  assign ySum  = {1'b0, yStart} + {1'b0, heightReg};
  assign xNext = {1'b0, mem.memoryXCoord} + 1'b1;
  assign yNext = {1'b0, mem.memoryYCoord} + 1'b1;
  assign offScreen = ({1'b0, xStart} >= xLimit) || ({1'b0, yStart} >= yLimit);
  assign emptyFill = (widthReg == '0) || (heightReg == '0) || offScreen;
  // Only the complete pulse matching the outstanding request type counts
  assign completeSeen = opRead ? mem.memoryReadComplete : mem.memoryWriteComplete;

  // Command sequencer: all outputs are registered here
  always_ff @(posedge clock) begin
    if (reset) begin
      state                  <= IDLE;
      cmdReady               <= 1'b0;
      busy                   <= 1'b0;
      readData               <= 8'h00;
      readDataValid          <= 1'b0;
      mem.memoryXCoord       <= '0;
      mem.memoryYCoord       <= '0;
      mem.memoryWriteRequest <= 1'b0;
      mem.memoryReadRequest  <= 1'b0;
      mem.memoryWriteData    <= 8'h00;
      opRead                 <= 1'b0;
      xStart                 <= '0;
      yStart                 <= '0;
      widthReg               <= '0;
      heightReg              <= '0;
      colorReg               <= 8'h00;
      xEnd                   <= '0;
      yEnd                   <= '0;
    end else begin
      readDataValid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmdValid && cmdReady) begin
            opRead    <= cmdOp;
            xStart    <= cmdX;
            yStart    <= cmdY;
            widthReg  <= cmdWidth;
            heightReg <= cmdHeight;
            colorReg  <= cmdColor;
            cmdReady  <= 1'b0;
            busy      <= 1'b1;
            state     <= SETUP;
          end else begin
            cmdReady <= 1'b1;
          end
        end
        SETUP: begin
          xEnd <= (xSum < xLimit) ? xSum : xLimit;
          yEnd <= (ySum < yLimit) ? ySum : yLimit;
          if (opRead ? offScreen : emptyFill) begin
            busy     <= 1'b0;
            cmdReady <= 1'b1;
            state    <= IDLE;
          end else begin
            mem.memoryXCoord       <= xStart;
            mem.memoryYCoord       <= yStart;
            mem.memoryWriteData    <= colorReg;
            mem.memoryWriteRequest <= ~opRead;
            mem.memoryReadRequest  <= opRead;
            state                  <= REQ;
          end
        end
        REQ: begin
          if (completeSeen) begin
            mem.memoryWriteRequest <= 1'b0;
            mem.memoryReadRequest  <= 1'b0;
            if (opRead) begin
              readData      <= mem.memoryReadData;
              readDataValid <= 1'b1;
            end
            state <= STEP;
          end
        end
        STEP: begin
          if (opRead) begin
            busy     <= 1'b0;
            cmdReady <= 1'b1;
            state    <= IDLE;
          end else if (xNext < xEnd) begin
            mem.memoryXCoord       <= xNext[X_BITS-1:0];
            mem.memoryWriteRequest <= 1'b1;
            state                  <= REQ;
          end else if (yNext < yEnd) begin
            mem.memoryXCoord       <= xStart;
            mem.memoryYCoord       <= yNext[Y_BITS-1:0];
            mem.memoryWriteRequest <= 1'b1;
            state                  <= REQ;
          end else begin
            busy     <= 1'b0;
            cmdReady <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_framebuffer_client.sv
// tb/tb_framebuffer_client.sv - scoreboard bench for framebuffer_client
module tb_framebuffer_client;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cmdValid = 1'b0;
  logic       cmdReady;
  logic       cmdOp = 1'b0;
  logic [8:0] cmdX = '0;
  logic [7:0] cmdY = '0;
  logic [8:0] cmdWidth = '0;
  logic [7:0] cmdHeight = '0;
  logic [7:0] cmdColor = '0;
  logic [7:0] readData;
  logic       readDataValid;
  logic       busy;

  framebuffer_client_if #(.X_BITS(9), .Y_BITS(8)) mem ();

  framebuffer_client dut (
    .clock(clock), .reset(reset), .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdOp(cmdOp),
    .cmdX(cmdX), .cmdY(cmdY), .cmdWidth(cmdWidth), .cmdHeight(cmdHeight), .cmdColor(cmdColor),
    .readData(readData), .readDataValid(readDataValid), .busy(busy), .mem(mem)
  );

  always #5 clock = ~clock;

  typedef struct {
    int kind;   // 0 write handshake, 1 read handshake, 2 readDataValid
    int x;
    int y;
    int data;
    int gap;    // cycles since accept/previous complete (kinds 0,1) or since complete (kind 2)
  } evType;

  evType expQ[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // responder controls
  int   respLat = 5;
  logic [7:0] respData = 8'h00;
  bit   injW = 0;
  bit   injR = 0;

  // monitor state
  int   reqRises = 0;
  int   refCycle = 0;
  int   riseCycle = 0;
  int   lastComplete = 0;
  int   acceptCycle = 0;
  int   riseGap = 0;
  int   riseX = 0, riseY = 0, riseD = 0;
  bit   prevReq = 0;
  bit   bothSeen = 0;
  bit   unstable = 0;
  evType got;
  evType e;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic evType mkEv(int kind, int x, int y, int data, int gap);
    evType v;
    v.kind = kind; v.x = x; v.y = y; v.data = data; v.gap = gap;
    return v;
  endfunction

  // Memory manager model: completes each request respLat cycles after it rises
  initial begin : responder
    int  cnt;
    bit  pulsed;
    bit  nextW, nextR;
    cnt = 0; pulsed = 0;
    mem.memoryWriteComplete = 1'b0;
    mem.memoryReadComplete  = 1'b0;
    mem.memoryReadData      = 8'h00;
    forever begin
      @(posedge clock);
      #1;
      nextW = 0; nextR = 0;
      if (mem.memoryWriteRequest || mem.memoryReadRequest) begin
        if (!pulsed) begin
          if (cnt == respLat) begin
            if (mem.memoryWriteRequest) nextW = 1; else nextR = 1;
            pulsed = 1;
          end else begin
            cnt++;
          end
        end
      end else begin
        cnt = 0;
        pulsed = 0;
      end
      if (injW) begin nextW = 1; injW = 0; end
      if (injR) begin nextR = 1; injR = 0; end
      mem.memoryWriteComplete = nextW;
      mem.memoryReadComplete  = nextR;
      mem.memoryReadData      = nextR ? respData : 8'h00;
    end
  end

  task automatic compareEv(input evType g);
    checks++;
    if (expQ.size() == 0) begin
      errors++;
      $display("FAIL event: got kind=%0d x=%0d y=%0d data=%02h gap=%0d, required none", g.kind, g.x, g.y, g.data, g.gap);
    end else begin
      e = expQ.pop_front();
      if (g.kind != e.kind || g.x != e.x || g.y != e.y || g.data != e.data || g.gap != e.gap) begin
        errors++;
        $display("FAIL event: got kind=%0d x=%0d y=%0d data=%02h gap=%0d, required kind=%0d x=%0d y=%0d data=%02h gap=%0d",
                 g.kind, g.x, g.y, g.data, g.gap, e.kind, e.x, e.y, e.data, e.gap);
      end
    end
  endtask

  // Monitor: turns observed handshakes and readDataValid pulses into events
  always @(negedge clock) begin : monitor
    bit req;
    req = mem.memoryWriteRequest || mem.memoryReadRequest;
    if (mem.memoryWriteRequest && mem.memoryReadRequest) bothSeen = 1;
    if (cmdValid && cmdReady && !reset) begin
      refCycle = cyc;
      acceptCycle = cyc;
    end
    if (req && !prevReq) begin
      reqRises++;
      riseCycle = cyc;
      riseGap = cyc - refCycle;
      riseX = int'(mem.memoryXCoord);
      riseY = int'(mem.memoryYCoord);
      riseD = int'(mem.memoryWriteData);
    end
    if (req && (int'(mem.memoryXCoord) != riseX || int'(mem.memoryYCoord) != riseY ||
                int'(mem.memoryWriteData) != riseD)) unstable = 1;
    if (mem.memoryWriteRequest && mem.memoryWriteComplete) begin
      got = mkEv(0, int'(mem.memoryXCoord), int'(mem.memoryYCoord), int'(mem.memoryWriteData), riseGap);
      compareEv(got);
      refCycle = cyc;
      lastComplete = cyc;
    end
    if (mem.memoryReadRequest && mem.memoryReadComplete) begin
      got = mkEv(1, int'(mem.memoryXCoord), int'(mem.memoryYCoord), 0, riseGap);
      compareEv(got);
      refCycle = cyc;
      lastComplete = cyc;
    end
    if (readDataValid) begin
      got = mkEv(2, 0, 0, int'(readData), cyc - lastComplete);
      compareEv(got);
    end
    prevReq = req;
  end

  task automatic check(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, actual, required);
    end
  endtask

  task automatic sendCmd(input bit op, input int x, input int y, input int w, input int h, input int c);
    bit ok;
    @(posedge clock);
    #1;
    cmdOp = op; cmdX = 9'(x); cmdY = 8'(y); cmdWidth = 9'(w); cmdHeight = 8'(h); cmdColor = 8'(c);
    cmdValid = 1'b1;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (cmdReady) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL cmd_accept: got cmdReady=0 for 100 cycles, required 1");
    end
    @(posedge clock);
    #1;
    cmdValid = 1'b0;
  endtask

  task automatic waitIdle(output int idleCyc, output int busyCyc);
    bit ok;
    ok = 0; busyCyc = 0; idleCyc = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clock);
      if (busy) busyCyc++;
      if (!busy && cmdReady) begin ok = 1; idleCyc = cyc; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_idle: got busy=%0d cmdReady=%0d after 500 cycles, required 0/1", busy, cmdReady);
    end
  endtask

  task automatic waitRises(input int target);
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      #1;
      if (reqRises >= target) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_request: got %0d request rises, required %0d", reqRises, target);
    end
  endtask

  initial begin : stimulus
    int idleCyc, busyCyc, base;

    // reset state
    repeat (3) @(negedge clock);
    check("reset_outputs", int'({cmdReady, busy, mem.memoryWriteRequest, mem.memoryReadRequest,
                                 mem.memoryXCoord, mem.memoryYCoord, mem.memoryWriteData,
                                 readData, readDataValid}), 0);
    reset = 1'b0;
    @(negedge clock);
    check("ready_after_reset", int'(cmdReady), 1);

    // 2x2 fill, responder latency 5
    respLat = 5;
    expQ.push_back(mkEv(0, 10, 20, 8'h5A, 2));
    expQ.push_back(mkEv(0, 11, 20, 8'h5A, 2));
    expQ.push_back(mkEv(0, 10, 21, 8'h5A, 2));
    expQ.push_back(mkEv(0, 11, 21, 8'h5A, 2));
    sendCmd(0, 10, 20, 2, 2, 8'h5A);
    waitIdle(idleCyc, busyCyc);
    check("fill_idle_after_last_complete", idleCyc - lastComplete, 2);
    check("fill_total_cycles", idleCyc - acceptCycle, 4 * (5 + 2) + 2);
    check("fill_queue_drained", expQ.size(), 0);

    // clipped fill at the bottom-right corner
    respLat = 2;
    expQ.push_back(mkEv(0, 318, 239, 8'h77, 2));
    expQ.push_back(mkEv(0, 319, 239, 8'h77, 2));
    base = reqRises;
    sendCmd(0, 318, 239, 5, 3, 8'h77);
    waitIdle(idleCyc, busyCyc);
    check("clip_request_count", reqRises - base, 2);
    check("clip_queue_drained", expQ.size(), 0);

    // empty fills: zero width, then x off-screen
    base = reqRises;
    sendCmd(0, 10, 10, 0, 4, 8'h33);
    waitIdle(idleCyc, busyCyc);
    check("noop_w0_busy_le2", int'(busyCyc >= 1 && busyCyc <= 2), 1);
    sendCmd(0, 320, 10, 4, 4, 8'h33);
    waitIdle(idleCyc, busyCyc);
    check("noop_x320_busy_le2", int'(busyCyc >= 1 && busyCyc <= 2), 1);
    check("noop_no_requests", reqRises - base, 0);

    // pixel read, latency 3
    respLat = 3;
    respData = 8'hC3;
    expQ.push_back(mkEv(1, 5, 7, 0, 2));
    expQ.push_back(mkEv(2, 0, 0, 8'hC3, 1));
    sendCmd(1, 5, 7, 0, 0, 0);
    waitIdle(idleCyc, busyCyc);
    check("read_queue_drained", expQ.size(), 0);
    check("read_data_held", int'(readData), 8'hC3);

    // off-screen read leaves readData alone and never pulses valid
    respData = 8'h99;
    base = reqRises;
    sendCmd(1, 320, 0, 0, 0, 0);
    waitIdle(idleCyc, busyCyc);
    check("read_offscreen_no_request", reqRises - base, 0);
    check("read_offscreen_data_kept", int'(readData), 8'hC3);

    // spurious complete pulses
    respLat = 4;
    injW = 1;
    repeat (3) @(negedge clock);
    expQ.push_back(mkEv(0, 100, 50, 8'h11, 2));
    expQ.push_back(mkEv(0, 101, 50, 8'h11, 2));
    base = reqRises;
    sendCmd(0, 100, 50, 2, 1, 8'h11);
    waitRises(base + 1);
    injR = 1;
    waitIdle(idleCyc, busyCyc);
    check("spurious_request_count", reqRises - base, 2);
    check("spurious_queue_drained", expQ.size(), 0);

    // reset during the third write of a 4x4 fill
    respLat = 4;
    expQ.push_back(mkEv(0, 4, 4, 8'hAB, 2));
    expQ.push_back(mkEv(0, 5, 4, 8'hAB, 2));
    base = reqRises;
    sendCmd(0, 4, 4, 4, 4, 8'hAB);
    waitRises(base + 3);
    reset = 1'b1;
    @(negedge clock);
    check("reset_mid_requests", int'({mem.memoryWriteRequest, mem.memoryReadRequest}), 0);
    check("reset_mid_busy", int'(busy), 0);
    reset = 1'b0;
    check("reset_mid_queue", expQ.size(), 0);
    expQ.push_back(mkEv(0, 0, 0, 8'hE1, 2));
    sendCmd(0, 0, 0, 1, 1, 8'hE1);
    waitIdle(idleCyc, busyCyc);
    check("after_reset_queue_drained", expQ.size(), 0);

    repeat (3) @(negedge clock);
    check("request_exclusive", int'(bothSeen), 0);
    check("request_stable", int'(unstable), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
